// File: rtl/dl_ram_arbiter.sv
// Arbitrates the single external RAM port between the data_io download write
// stream (one-entry buffer, highest priority) and the CPU memory port.
module dl_ram_arbiter #(
   parameter int AW      = 25,
   parameter int TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          dl_active,
   input  logic          dl_wr,
   input  logic [AW-1:0] dl_addr,
   input  logic [15:0]   dl_data,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [1:0]    cpu_be,
   input  logic [AW-1:0] cpu_addr,
   input  logic [15:0]   cpu_din,
   output logic [15:0]   cpu_dout,
   output logic          cpu_ack,
   output logic          cpu_hold,
   output logic          ram_req,
   output logic          ram_we,
   output logic [1:0]    ram_be,
   output logic [AW-1:0] ram_addr,
   output logic [15:0]   ram_din,
   input  logic [15:0]   ram_dout,
   input  logic          ram_ack,
   output logic [23:0]   dl_words,
   output logic          dl_overrun,
   output logic          ram_timeout,
   output logic [1:0]    dbg_state
);

   // Handshake: ram_req rises with a registered address/data/we/be and stays
   // high until the cycle ram_ack=1 is sampled; ram_req is low the cycle after.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DL   = 2'd1,
      S_CPU  = 2'd2
   } state_e;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_e          state_q, state_d;
   logic            dl_wr_q, dl_active_q;
   logic            buf_full_q, buf_full_d;
   logic            buf_next_q, buf_next_d;
   logic [AW-1:0]   buf_addr_q, buf_addr_d;
   logic [15:0]     buf_data_q, buf_data_d;
   logic [7:0]      tmo_cnt_q, tmo_cnt_d;
   logic            ram_req_q, ram_req_d;
   logic            ram_we_q, ram_we_d;
   logic [1:0]      ram_be_q, ram_be_d;
   logic [AW-1:0]   ram_addr_q, ram_addr_d;
   logic [15:0]     ram_din_q, ram_din_d;
   logic [15:0]     cpu_dout_q, cpu_dout_d;
   logic            cpu_ack_q, cpu_ack_d;
   logic            cpu_hold_q, cpu_hold_d;
   logic [23:0]     dl_words_q, dl_words_d;
   logic            dl_overrun_q, dl_overrun_d;
   logic            ram_timeout_q, ram_timeout_d;

   logic dl_edge, dl_rise, issue_dl, busy, tmo_hit, acc_end, entering;

   assign dl_edge  = dl_wr & ~dl_wr_q;
   assign dl_rise  = dl_active & ~dl_active_q;
   assign issue_dl = (state_q == S_IDLE) & buf_full_q;
   assign busy     = (state_q == S_DL) | (state_q == S_CPU);
   assign tmo_hit  = busy & ~ram_ack & (tmo_cnt_q == TMO_LAST);
   assign acc_end  = busy & (ram_ack | tmo_hit);
   assign entering = (state_q == S_IDLE) & (state_d != S_IDLE);

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (buf_full_q)                 state_d = S_DL;
            else if (cpu_req && !cpu_hold_q) state_d = S_CPU;
         end
         S_DL, S_CPU: begin
            if (ram_ack || tmo_hit) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output / datapath logic
   always_comb begin
      buf_full_d    = buf_full_q;
      buf_next_d    = buf_next_q;
      buf_addr_d    = buf_addr_q;
      buf_data_d    = buf_data_q;
      tmo_cnt_d     = 8'd0;
      ram_req_d     = ram_req_q;
      ram_we_d      = ram_we_q;
      ram_be_d      = ram_be_q;
      ram_addr_d    = ram_addr_q;
      ram_din_d     = ram_din_q;
      cpu_dout_d    = cpu_dout_q;
      cpu_ack_d     = 1'b0;
      dl_words_d    = dl_words_q;
      dl_overrun_d  = dl_overrun_q;
      ram_timeout_d = ram_timeout_q;
      cpu_hold_d    = dl_active | buf_full_q | (state_q == S_DL);

      if (dl_rise) begin
         dl_words_d    = 24'd0;
         dl_overrun_d  = 1'b0;
         ram_timeout_d = 1'b0;
      end

      if (busy) tmo_cnt_d = tmo_cnt_q + 8'd1;

      if (entering) begin
         ram_req_d = 1'b1;
         if (state_d == S_DL) begin
            ram_we_d   = 1'b1;
            ram_be_d   = 2'b11;
            ram_addr_d = buf_addr_q;
            ram_din_d  = buf_data_q;
         end else begin
            ram_we_d   = cpu_we;
            ram_be_d   = cpu_be;
            ram_addr_d = cpu_addr;
            ram_din_d  = cpu_din;
         end
      end

      if (acc_end) begin
         ram_req_d = 1'b0;
         if (tmo_hit) ram_timeout_d = 1'b1;
         if (state_q == S_DL) begin
            if (ram_ack) dl_words_d = dl_words_d + 24'd1;
            // A word captured while the previous one was being issued survives
            if (buf_next_q) buf_next_d = 1'b0;
            else            buf_full_d = 1'b0;
         end else begin
            cpu_ack_d  = 1'b1;
            cpu_dout_d = ram_ack ? ram_dout : 16'hFFFF;
         end
      end

      if (dl_edge) begin
         if (!buf_full_q || (issue_dl && !buf_next_q)) begin
            buf_full_d = 1'b1;
            buf_next_d = issue_dl;
            buf_addr_d = dl_addr;
            buf_data_d = dl_data;
         end else begin
            dl_overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dl_wr_q       <= 1'b0;
         dl_active_q   <= 1'b0;
         buf_full_q    <= 1'b0;
         buf_next_q    <= 1'b0;
         buf_addr_q    <= '0;
         buf_data_q    <= 16'd0;
         tmo_cnt_q     <= 8'd0;
         ram_req_q     <= 1'b0;
         ram_we_q      <= 1'b0;
         ram_be_q      <= 2'b00;
         ram_addr_q    <= '0;
         ram_din_q     <= 16'd0;
         cpu_dout_q    <= 16'd0;
         cpu_ack_q     <= 1'b0;
         cpu_hold_q    <= 1'b0;
         dl_words_q    <= 24'd0;
         dl_overrun_q  <= 1'b0;
         ram_timeout_q <= 1'b0;
      end else begin
         dl_wr_q       <= dl_wr;
         dl_active_q   <= dl_active;
         buf_full_q    <= buf_full_d;
         buf_next_q    <= buf_next_d;
         buf_addr_q    <= buf_addr_d;
         buf_data_q    <= buf_data_d;
         tmo_cnt_q     <= tmo_cnt_d;
         ram_req_q     <= ram_req_d;
         ram_we_q      <= ram_we_d;
         ram_be_q      <= ram_be_d;
         ram_addr_q    <= ram_addr_d;
         ram_din_q     <= ram_din_d;
         cpu_dout_q    <= cpu_dout_d;
         cpu_ack_q     <= cpu_ack_d;
         cpu_hold_q    <= cpu_hold_d;
         dl_words_q    <= dl_words_d;
         dl_overrun_q  <= dl_overrun_d;
         ram_timeout_q <= ram_timeout_d;
      end
   end

   assign cpu_dout    = cpu_dout_q;
   assign cpu_ack     = cpu_ack_q;
   assign cpu_hold    = cpu_hold_q;
   assign ram_req     = ram_req_q;
   assign ram_we      = ram_we_q;
   assign ram_be      = ram_be_q;
   assign ram_addr    = ram_addr_q;
   assign ram_din     = ram_din_q;
   assign dl_words    = dl_words_q;
   assign dl_overrun  = dl_overrun_q;
   assign ram_timeout = ram_timeout_q;
   assign dbg_state   = state_q;

endmodule

// File: doc/dl_ram_arbiter.md
Name: dl_ram_arbiter

Overview:
- Shares the single external RAM port between the file-download write stream (data_io wr/a/d) and the CPU memory port.
- Captures each download word write into a one-entry buffer and gives it priority over CPU traffic.
- Holds the CPU off for the whole download, counts words written, and flags overruns and RAM timeouts.
- Sits between data_io, the CPU bus bridge and the SDRAM controller.

Parameters:
- AW, 25, RAM byte-address width.
- TIMEOUT, 255, max clk cycles to wait for ram_ack before abort (8-bit counter range).

Ports:
- clk  in  1  system clock (same clk as data_io)
- reset_n  in  1  asynchronous, active-low reset
- dl_active  in  1  download in progress (data_io downloading)
- dl_wr  in  1  download write strobe, level, asserted 2 clk per word
- dl_addr  in  AW  download word byte-address (bit0 = 0)
- dl_data  in  16  download word
- cpu_req  in  1  CPU access request, level, held until cpu_ack
- cpu_we  in  1  CPU write enable
- cpu_be  in  2  CPU byte enables
- cpu_addr  in  AW  CPU byte address
- cpu_din  in  16  CPU write data
- cpu_dout  out  16  CPU read data
- cpu_ack  out  1  one-cycle completion pulse to CPU
- cpu_hold  out  1  CPU stall/reset request
- ram_req  out  1  RAM request, held until ram_ack
- ram_we  out  1  RAM write enable
- ram_be  out  2  RAM byte enables
- ram_addr  out  AW  RAM address
- ram_din  out  16  RAM write data
- ram_dout  in  16  RAM read data
- ram_ack  in  1  one-cycle RAM completion pulse
- dl_words  out  24  words written in current/last download
- dl_overrun  out  1  sticky: download word lost
- ram_timeout  out  1  sticky: RAM access aborted

Behaviour:
- Reset (async, reset_n=0): all outputs 0, FSM IDLE, buffer empty, counters 0, flags 0.
- Edge capture: register dl_wr; on a 0->1 edge latch dl_addr/dl_data into the buffer and set buf_full. The second cycle of the 2-cycle strobe must not capture again.
- Edge while buf_full: keep the old buffer contents, drop the new word, set dl_overrun (sticky).
- Edge in the same cycle the buffered word is being issued (IDLE->DL): the new word is captured, not an overrun.
- dl_active 0->1 edge: clear dl_words, dl_overrun and ram_timeout.
- cpu_hold = dl_active | buf_full | (state==DL). It is registered, so it rises 1 clk after dl_active.
- FSM states: IDLE, DL, CPU.
  - IDLE: buf_full -> DL. Else cpu_req & !cpu_hold -> CPU. Else stay.
  - On entering DL or CPU, drive ram_req=1 with addr/data/we/be registered the same cycle. DL uses we=1, be=2'b11.
  - DL: ram_ack -> clear buf_full, dl_words+1, return to IDLE.
  - CPU: ram_ack -> cpu_dout<=ram_dout, cpu_ack=1 for 1 clk, return to IDLE.
- ram_req stays high until the ram_ack cycle; it deasserts on the cycle after ram_ack is seen. Back-to-back accesses need at least 1 IDLE cycle between them.
- Priority: a pending download word always wins over CPU. A CPU access already in CPU state completes before the download word is issued.
- Timeout: an 8-bit counter runs in DL/CPU and clears on state entry. When the count reaches TIMEOUT without ram_ack:
  - drop ram_req, set ram_timeout, return to IDLE;
  - DL: clear buf_full and do not increment dl_words;
  - CPU: pulse cpu_ack with cpu_dout=16'hFFFF.
- ram_ack while IDLE is ignored.
- cpu_req present while cpu_hold=1 gets no ack and waits.
- dl_words wraps modulo 2^24.

Test Plan:
- Reset mid-CPU-access (reset_n low while ram_req=1) -> all outputs 0 immediately, FSM IDLE, no cpu_ack after release.
- CPU read, addr 0x000100, RAM acks after 3 clk with 0xBEEF -> ram_req held 3 clk, cpu_ack 1-cycle pulse, cpu_dout=0xBEEF.
- Download 4 words starting at 0x0E0000, 2-clk dl_wr strobes 20 clk apart, RAM ack latency 2 -> exactly 4 RAM writes, be=11, addrs 0x0E0000..0x0E0006, dl_words=4, dl_overrun=0.
- CPU request pending while dl_active rises -> CPU access withheld until dl_active=0 and buffer empty, then served; download writes all complete first.
- Two dl_wr edges 3 clk apart with RAM ack latency 10 -> second word dropped, first word written, dl_overrun=1, dl_words=1; flags clear on next dl_active rise.
- RAM never acks a CPU write, TIMEOUT=255 -> ram_req drops after 255 clk, ram_timeout=1, cpu_ack pulsed, FSM back in IDLE.
